// File: rtl/pong_game_engine.sv
// Pong game engine: ball, paddle and score state advanced once per video frame tick.
// All outputs are registered; the POINT state lasts a single clk50M cycle.
module pong_game_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_SPEED = 4,
  parameter int P1_X         = 600,
  parameter int P2_X         = 0,
  parameter int SERVE_DELAY  = 60,
  parameter int SCORE_MAX    = 9
) (
  input  logic       clk50M,
  input  logic       reset_n,
  input  logic       endofframe,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       serve_req,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_one_y,
  output logic [9:0] paddle_two_y,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    POINT      = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  localparam int              CW       = $clog2(SERVE_DELAY + 1);
  localparam logic [9:0]      BX0      = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]      BY0      = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0]      PY0      = 10'((V_RES - PADDLE_H) / 2);
  localparam logic [10:0]     PAD_MAX  = 11'(V_RES - PADDLE_H);
  localparam logic [10:0]     BY_MAX   = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0]     BX_MAX   = 11'(H_RES - BALL_SIZE);
  localparam logic [10:0]     BS       = 11'(BALL_SIZE);
  localparam logic [10:0]     SPD      = 11'(BALL_SPEED);
  localparam logic [10:0]     PSPD     = 11'(PADDLE_SPEED);
  localparam logic [10:0]     PH       = 11'(PADDLE_H);
  localparam logic [10:0]     X1       = 11'(P1_X);
  localparam logic [10:0]     X2R      = 11'(P2_X + PADDLE_W);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [3:0]      SMAX     = 4'(SCORE_MAX);

  state_t        cur, nxt;
  logic          dx, dy, point_two;
  logic [CW-1:0] cnt;

  logic [9:0]    bx_d, by_d, p1_d, p2_d;
  logic [3:0]    s1_d, s2_d;
  logic          go_d, dx_d, dy_d, pt2_d;
  logic [CW-1:0] cnt_d;

  logic [10:0]   bxw, byw, p1w, p2w;
  logic          hit_one, hit_two, miss_right, miss_left;
  logic [9:0]    x_step, y_step, p1_step, p2_step;
  logic          dy_step;
  logic [3:0]    score_inc;

  function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up,
                                             input logic down);
    logic [10:0] yw;
    yw = {1'b0, y};
    paddle_step = y;
    if (up && !down)
      paddle_step = (yw < PSPD) ? '0 : 10'(yw - PSPD);
    else if (down && !up)
      paddle_step = (yw + PSPD > PAD_MAX) ? 10'(PAD_MAX) : 10'(yw + PSPD);
  endfunction

  // Candidate ball motion, evaluated against the paddle positions held before this tick.
  always_comb begin
    bxw        = {1'b0, ball_x};
    byw        = {1'b0, ball_y};
    p1w        = {1'b0, paddle_one_y};
    p2w        = {1'b0, paddle_two_y};
    p1_step    = paddle_step(paddle_one_y, p1_up, p1_down);
    p2_step    = paddle_step(paddle_two_y, p2_up, p2_down);
    hit_one    = dx && (bxw + BS <= X1) && (bxw + BS + SPD >= X1)
                 && (byw + BS > p1w) && (byw < p1w + PH);
    hit_two    = !dx && (bxw >= X2R) && (bxw <= X2R + SPD)
                 && (byw + BS > p2w) && (byw < p2w + PH);
    miss_right = dx && (bxw + SPD > BX_MAX);
    miss_left  = !dx && (bxw < SPD);
    x_step     = dx ? 10'(bxw + SPD) : 10'(bxw - SPD);
    // Wall limits are tested per direction, so the signed "next y <= 0" never materialises.
    if (dy) begin
      if (byw + SPD >= BY_MAX) begin
        y_step  = 10'(BY_MAX);
        dy_step = 1'b0;
      end else begin
        y_step  = 10'(byw + SPD);
        dy_step = 1'b1;
      end
    end else begin
      if (byw <= SPD) begin
        y_step  = '0;
        dy_step = 1'b1;
      end else begin
        y_step  = 10'(byw - SPD);
        dy_step = 1'b0;
      end
    end
    score_inc  = (point_two ? score_two : score_one) + 4'd1;
  end

  always_comb begin
    nxt   = cur;
    bx_d  = ball_x;
    by_d  = ball_y;
    p1_d  = paddle_one_y;
    p2_d  = paddle_two_y;
    s1_d  = score_one;
    s2_d  = score_two;
    go_d  = game_over;
    dx_d  = dx;
    dy_d  = dy;
    cnt_d = cnt;
    pt2_d = point_two;
    case (cur)
      IDLE: begin
        if (serve_req) begin
          nxt   = SERVE_WAIT;
          cnt_d = '0;
        end
      end
      SERVE_WAIT: begin
        if (endofframe) begin
          p1_d  = p1_step;
          p2_d  = p2_step;
          cnt_d = cnt + CW'(1);
          if (cnt == CNT_LAST) nxt = PLAY;
        end
      end
      PLAY: begin
        if (endofframe) begin
          p1_d = p1_step;
          p2_d = p2_step;
          if (hit_one) begin
            bx_d = 10'(X1 - BS);
            dx_d = 1'b0;
            by_d = y_step;
            dy_d = dy_step;
          end else if (hit_two) begin
            bx_d = 10'(X2R);
            dx_d = 1'b1;
            by_d = y_step;
            dy_d = dy_step;
          end else if (miss_right || miss_left) begin
            nxt   = POINT;
            pt2_d = miss_right;
          end else begin
            bx_d = x_step;
            by_d = y_step;
            dy_d = dy_step;
          end
        end
      end
      POINT: begin
        if (point_two) s2_d = score_inc;
        else           s1_d = score_inc;
        if (score_inc == SMAX) begin
          nxt  = GAME_OVER;
          go_d = 1'b1;
        end else begin
          nxt   = SERVE_WAIT;
          bx_d  = BX0;
          by_d  = BY0;
          dx_d  = point_two;
          cnt_d = '0;
        end
      end
      GAME_OVER: begin
        if (serve_req) begin
          nxt   = SERVE_WAIT;
          s1_d  = '0;
          s2_d  = '0;
          go_d  = 1'b0;
          bx_d  = BX0;
          by_d  = BY0;
          cnt_d = '0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      cur          <= IDLE;
      ball_x       <= BX0;
      ball_y       <= BY0;
      paddle_one_y <= PY0;
      paddle_two_y <= PY0;
      score_one    <= '0;
      score_two    <= '0;
      game_over    <= 1'b0;
      dx           <= 1'b1;
      dy           <= 1'b1;
      cnt          <= '0;
      point_two    <= 1'b0;
    end else begin
      cur          <= nxt;
      ball_x       <= bx_d;
      ball_y       <= by_d;
      paddle_one_y <= p1_d;
      paddle_two_y <= p2_d;
      score_one    <= s1_d;
      score_two    <= s2_d;
      game_over    <= go_d;
      dx           <= dx_d;
      dy           <= dy_d;
      cnt          <= cnt_d;
      point_two    <= pt2_d;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine: frame-level game model checked every cycle, plus literal pins.
module tb_pong_game_engine;

  localparam int CX = 316, CY = 236, PC = 208, PMAX = 416, YMAX = 472, XMAX = 632;
  localparam int SPD = 2, PSPD = 4, BSZ = 8, PH = 64, X1 = 600, X2R = 8;
  localparam int DELAY = 60, SMAX = 9;

  logic       clk = 1'b0;
  logic       reset_n, endofframe, p1_up, p1_down, p2_up, p2_down, serve_req;
  logic [9:0] ball_x, ball_y, paddle_one_y, paddle_two_y;
  logic [3:0] score_one, score_two;
  logic       game_over;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: 0 idle, 1 serve wait, 2 play, 3 point, 4 game over
  int m_state, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_go, m_cnt, m_pt2;
  int mode1, mode2;

  pong_game_engine dut (
    .clk50M      (clk),
    .reset_n     (reset_n),
    .endofframe  (endofframe),
    .p1_up       (p1_up),
    .p1_down     (p1_down),
    .p2_up       (p2_up),
    .p2_down     (p2_down),
    .serve_req   (serve_req),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .paddle_one_y(paddle_one_y),
    .paddle_two_y(paddle_two_y),
    .score_one   (score_one),
    .score_two   (score_two),
    .game_over   (game_over),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1;
    m_p1 = PC; m_p2 = PC; m_s1 = 0; m_s2 = 0; m_go = 0; m_cnt = 0; m_pt2 = 0;
  endtask

  function automatic int pmove(input int p, input logic up, input logic dn);
    if (up && !dn) return (p - PSPD < 0) ? 0 : p - PSPD;
    if (dn && !up) return (p + PSPD > PMAX) ? PMAX : p + PSPD;
    return p;
  endfunction

  function automatic bit covers(input int by, input int p);
    return (by + BSZ > p) && (by < p + PH);
  endfunction

  task automatic model_step();
    int ny, ndy;
    bit h1, h2;
    case (m_state)
      0: if (serve_req) begin m_state = 1; m_cnt = 0; end
      1: if (endofframe) begin
        m_p1 = pmove(m_p1, p1_up, p1_down);
        m_p2 = pmove(m_p2, p2_up, p2_down);
        m_cnt++;
        if (m_cnt == DELAY) m_state = 2;
      end
      2: if (endofframe) begin
        ny  = m_by + (m_dy != 0 ? SPD : -SPD);
        ndy = m_dy;
        if (ny <= 0) begin ny = 0; ndy = 1; end
        else if (ny >= YMAX) begin ny = YMAX; ndy = 0; end
        h1 = (m_dx == 1) && (m_bx + BSZ <= X1) && (m_bx + BSZ + SPD >= X1) && covers(m_by, m_p1);
        h2 = (m_dx == 0) && (m_bx >= X2R) && (m_bx - SPD <= X2R) && covers(m_by, m_p2);
        if (h1) begin
          m_bx = X1 - BSZ; m_dx = 0; m_by = ny; m_dy = ndy;
        end else if (h2) begin
          m_bx = X2R; m_dx = 1; m_by = ny; m_dy = ndy;
        end else if (m_dx == 1 && m_bx + SPD > XMAX) begin
          m_state = 3; m_pt2 = 1;
        end else if (m_dx == 0 && m_bx < SPD) begin
          m_state = 3; m_pt2 = 0;
        end else begin
          m_bx = m_bx + (m_dx == 1 ? SPD : -SPD); m_by = ny; m_dy = ndy;
        end
        m_p1 = pmove(m_p1, p1_up, p1_down);
        m_p2 = pmove(m_p2, p2_up, p2_down);
      end
      3: begin
        if (m_pt2 == 1) m_s2++; else m_s1++;
        if (m_s1 == SMAX || m_s2 == SMAX) begin
          m_state = 4; m_go = 1;
        end else begin
          m_state = 1; m_bx = CX; m_by = CY; m_dx = m_pt2; m_cnt = 0;
        end
      end
      4: if (serve_req) begin
        m_state = 1; m_s1 = 0; m_s2 = 0; m_go = 0; m_bx = CX; m_by = CY; m_cnt = 0;
      end
      default: ;
    endcase
  endtask

  // Outputs sampled on the falling edge, then the model advanced with the inputs
  // that the next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) model_reset();
      chk("state", int'(state), m_state);
      chk("ball_x", int'(ball_x), m_bx);
      chk("ball_y", int'(ball_y), m_by);
      chk("paddle_one_y", int'(paddle_one_y), m_p1);
      chk("paddle_two_y", int'(paddle_two_y), m_p2);
      chk("score_one", int'(score_one), m_s1);
      chk("score_two", int'(score_two), m_s2);
      chk("game_over", int'(game_over), m_go);
      if (reset_n) model_step();
    end
  end

  // modes: 0 none, 1 up, 2 down, 3 both, 4 track ball, 5 avoid ball
  task automatic ctl(input int mode, input int p, output logic up, output logic dn);
    int target;
    bit want_down;
    up = 1'b0;
    dn = 1'b0;
    case (mode)
      1: up = 1'b1;
      2: dn = 1'b1;
      3: begin up = 1'b1; dn = 1'b1; end
      4: begin
        target = m_by + BSZ / 2 - PH / 2;
        up = (p > target + 2);
        dn = (p < target - 2);
      end
      5: if ((m_by + 2 * BSZ > p) && (m_by < p + PH + BSZ)) begin
        want_down = (m_by + BSZ / 2 < p + PH / 2);
        if (want_down && p >= PMAX) want_down = 0;
        if (!want_down && p == 0) want_down = 1;
        up = !want_down;
        dn = want_down;
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    ctl(mode1, m_p1, p1_up, p1_down);
    ctl(mode2, m_p2, p2_up, p2_down);
    endofframe = 1'b1;
    @(posedge clk); #1;
    endofframe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_serve();
    serve_req = 1'b1;
    @(posedge clk); #1;
    serve_req = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_ball_x"}, int'(ball_x), CX);
    chk({tag, "_ball_y"}, int'(ball_y), CY);
    chk({tag, "_p1"}, int'(paddle_one_y), PC);
    chk({tag, "_p2"}, int'(paddle_two_y), PC);
    chk({tag, "_scores"}, int'(score_one) + int'(score_two), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
  endtask

  initial begin
    bit ok, pre, hit_seen;
    int saved_p1, saved_bx;
    reset_n = 1'b0; endofframe = 1'b0; serve_req = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    mode1 = 0; mode2 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_reset_values("reset");

    repeat (10) tick();
    chk("idle_hold_state", int'(state), 0);
    chk("idle_hold_ball_x", int'(ball_x), CX);

    pulse_serve();
    chk("serve_state", int'(state), 1);

    mode1 = 3; mode2 = 2;
    repeat (2) tick();
    chk("both_pressed_hold", int'(paddle_one_y), PC);
    mode1 = 1;
    repeat (DELAY - 3) tick();
    chk("serve_wait_59", int'(state), 1);
    tick();
    chk("serve_done_play", int'(state), 2);
    chk("p1_saturate_top", int'(paddle_one_y), 0);
    chk("p2_saturate_bottom", int'(paddle_two_y), PMAX);

    mode1 = 0; mode2 = 0;
    tick();
    chk("first_play_x", int'(ball_x), 318);
    chk("first_play_y", int'(ball_y), 238);

    // Right player dodges: point to player two.
    mode1 = 5;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (m_s2 == 1) ok = 1;
    end
    chk("miss_right_reached", int'(ok), 1);
    chk("miss_right_score_two", int'(score_two), 1);
    chk("miss_right_state", int'(state), 1);
    chk("miss_right_ball_x", int'(ball_x), CX);
    chk("miss_right_ball_y", int'(ball_y), CY);

    // Right player tracks, left player dodges: player one runs to the score limit.
    mode1 = 4; mode2 = 5;
    ok = 0; hit_seen = 0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      pre = (m_state == 2) && (m_dx == 1) && (m_bx == 590) && covers(m_by, m_p1);
      tick();
      if (pre && !hit_seen) begin
        hit_seen = 1;
        chk("p1_hit_x", int'(ball_x), 592);
      end
      if (m_go == 1) ok = 1;
    end
    chk("game_over_reached", int'(ok), 1);
    chk("final_score_one", int'(score_one), 9);
    chk("final_score_two", int'(score_two), 1);
    chk("final_state", int'(state), 4);
    chk("final_game_over", int'(game_over), 1);

    saved_p1 = m_p1; saved_bx = m_bx;
    mode1 = 2; mode2 = 1;
    repeat (5) tick();
    chk("frozen_p1", int'(paddle_one_y), saved_p1);
    chk("frozen_ball_x", int'(ball_x), saved_bx);
    chk("frozen_state", int'(state), 4);

    pulse_serve();
    chk("restart_state", int'(state), 1);
    chk("restart_scores", int'(score_one) + int'(score_two), 0);
    chk("restart_game_over", int'(game_over), 0);
    chk("restart_ball_x", int'(ball_x), CX);
    chk("restart_ball_y", int'(ball_y), CY);

    mode1 = 4; mode2 = 4;
    repeat (DELAY + 20) tick();
    chk("replay_state", int'(state), 2);

    // Asynchronous reset mid-play, away from any clock edge.
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    mode1 = 0; mode2 = 0;
    repeat (5) tick();
    chk("post_reset_state", int'(state), 0);
    chk("post_reset_ball_x", int'(ball_x), CX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
